dmem_responder: RTL and testbench

Word-addressed data-memory responder that serves the core's load/store port (d_addr, wdata, wea, rdata). It owns the data storage array, accepts one access per clock, and returns load data a fixed READ_LATENCY cycles later with an rvalid strobe. Out-of-range accesses are flagged and counted.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_rd_pipe.sv | 48 ++++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and limits for the data-memory responder
package dmem_pkg;

    // Legal range for the read pipeline depth.
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    typedef logic [31:0] word_t;

    // One slot of the read pipeline: a completed read with its range flag.
    typedef struct packed {
        logic  valid;
        logic  err;
        word_t data;
    } rd_entry_t;

endpackage

// File: rtl/dmem_rd_pipe.sv
// rtl/dmem_rd_pipe.sv - fixed-depth read result pipeline
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset (clears every stage)
//   in_entry   read result captured at the sampling edge
//   out_entry  final stage; data holds its last valid value between strobes
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  rd_entry_t in_entry,
    output rd_entry_t out_entry
);

    rd_entry_t stage [DEPTH];
    rd_entry_t src   [DEPTH];

    always_comb begin
        src[0] = in_entry;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = stage[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stage[i] <= src[i];
            end
            // The last stage drives rdata, which must hold between strobes.
            stage[DEPTH-1].valid <= src[DEPTH-1].valid;
            stage[DEPTH-1].err   <= src[DEPTH-1].err;
            if (src[DEPTH-1].valid) begin
                stage[DEPTH-1].data <= src[DEPTH-1].data;
            end
        end
    end

    assign out_entry = stage[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with pipelined reads and error counting
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   d_addr     word address; in range when d_addr[31:ADDR_W] == 0
//   ren, wea   read request and write enable, both may be set in one cycle
//   wdata      store data
//   rdata      load data, holds between rvalid strobes
//   rvalid     one-cycle strobe per completed read, READ_LATENCY after sampling
//   rerr       qualifies rvalid: the completed read was out of range
//   err        sticky out-of-range flag
//   err_cnt    saturating count of out-of-range accesses
//
// Build option: DMEM_WRITE_FIRST_EN selects write-first behaviour for a
// read and write issued together; otherwise the read sees the old contents.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int ERRCNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         d_addr,
    input  logic                ren,
    input  logic                wea,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                rvalid,
    output logic                rerr,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    generate
        if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
            $error("dmem_responder: READ_LATENCY must be within 1..4");
        end
    endgenerate

    word_t             mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              bypass;
    rd_entry_t         rd_in;
    rd_entry_t         rd_out;

    assign idx      = d_addr[ADDR_W-1:0];
    assign in_range = (d_addr[31:ADDR_W] == '0);

    // Read and write share d_addr, so a simultaneous pair always collides.
`ifdef DMEM_WRITE_FIRST_EN
    assign bypass = wea;
`else
    assign bypass = 1'b0;
`endif

    // Contents survive reset; no write is taken while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
        end else if (wea && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rd_in       = '0;
        rd_in.valid = ren;
        rd_in.err   = ren && !in_range;
        if (in_range) begin
            rd_in.data = bypass ? wdata : mem[idx];
        end
    end

    dmem_rd_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_entry  (rd_in),
        .out_entry (rd_out)
    );

    assign rdata  = rd_out.data;
    assign rvalid = rd_out.valid;
    assign rerr   = rd_out.valid && rd_out.err;

    // A combined read+write to a bad address counts twice.
    logic [1:0]        n_bad;
    logic [ERRCNT_W:0] cnt_sum;

    assign n_bad   = {1'b0, ren && !in_range} + {1'b0, wea && !in_range};
    assign cnt_sum = {1'b0, err_cnt} + {{(ERRCNT_W-1){1'b0}}, n_bad};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (n_bad != 2'd0) begin
                err <= 1'b1;
            end
            err_cnt <= cnt_sum[ERRCNT_W] ? {ERRCNT_W{1'b1}} : cnt_sum[ERRCNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized model-checked bench for dmem_responder
module tb_dmem_responder;

    localparam int L  = 2;
`ifdef DMEM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_addr = '0;
    logic        ren = 1'b0;
    logic        wea = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rerr;
    logic        err;
    logic [7:0]  err_cnt;

    dmem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .d_addr  (d_addr),
        .ren     (ren),
        .wea     (wea),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rerr    (rerr),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        bit          bad;
        logic [31:0] data;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] mem_m [1024];
    int          cyc = 0;
    bit          m_valid = 0;
    bit          m_rerr = 0;
    logic [31:0] m_rdata = '0;
    bit          m_err = 0;
    int          m_cnt = 0;

    initial for (int i = 0; i < 1024; i++) mem_m[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_valid = 0;
            m_rerr  = 0;
            m_rdata = '0;
            m_err   = 0;
            m_cnt   = 0;
        end else begin
            bit          bad;
            int          ix;
            int          nb;
            logic [31:0] rv;
            cyc++;
            bad = (d_addr / 1024) != 0;
            ix  = d_addr % 1024;
            if (ren) begin
                if (bad) rv = 32'h0;
                else if (WF && wea) rv = wdata;
                else rv = mem_m[ix];
                pend.push_back('{cyc + L - 1, bad, rv});
            end
            if (wea && !bad) mem_m[ix] = wdata;
            nb = (ren && bad ? 1 : 0) + (wea && bad ? 1 : 0);
            if (nb > 0) m_err = 1;
            m_cnt = (m_cnt + nb > 255) ? 255 : m_cnt + nb;
            m_valid = 0;
            m_rerr  = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                pend_t p;
                p = pend.pop_front();
                m_valid = 1;
                m_rerr  = p.bad;
                m_rdata = p.data;
            end
        end
    end

    // Compare process: outputs checked every cycle against the model.
    always @(negedge clk) begin
        chk("rvalid", {31'b0, rvalid}, {31'b0, m_valid});
        chk("rerr", {31'b0, rerr}, {31'b0, m_rerr});
        chk("rdata", rdata, m_rdata);
        chk("err", {31'b0, err}, {31'b0, m_err});
        chk("err_cnt", {24'b0, err_cnt}, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren = r; wea = w; d_addr = a; wdata = d;
        @(posedge clk); #2;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #2;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_cnt", {24'b0, err_cnt}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Write then read
        cycle(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 32'd5, 32'h0);
        idle();
        chk("wr_rd_valid", {31'b0, rvalid}, 32'd1);
        chk("wr_rd_data", rdata, 32'hDEADBEEF);
        idle();
        chk("wr_rd_pulse", {31'b0, rvalid}, 32'd0);
        chk("wr_rd_hold", rdata, 32'hDEADBEEF);

        // Reset mid-read
        cycle(1'b1, 1'b0, 32'd5, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge clk); #2;
        chk("rst_hold_rvalid", {31'b0, rvalid}, 32'd0);
        rst = 1'b0;
        idle();
        chk("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
        idle();
        cycle(1'b1, 1'b0, 32'd5, 32'h0);
        idle();
        chk("post_rst_data", rdata, 32'hDEADBEEF);

        // Streaming
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, i, 100 + i);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, i, 32'h0);
            if (i > 0) begin
                chk("stream_valid", {31'b0, rvalid}, 32'd1);
                chk("stream_data", rdata, 100 + i - 1);
            end
        end
        idle();
        chk("stream_last", rdata, 32'd107);

        // Same-cycle collision
        cycle(1'b0, 1'b1, 32'd3, 32'h1);
        cycle(1'b1, 1'b1, 32'd3, 32'h2);
        idle();
        chk("collide", rdata, WF ? 32'h2 : 32'h1);
        cycle(1'b1, 1'b0, 32'd3, 32'h0);
        idle();
        chk("collide_next", rdata, 32'h2);

        // Out of range
        do_reset();
        cycle(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        idle();
        chk("oor_rerr", {31'b0, rerr}, 32'd1);
        chk("oor_rdata", rdata, 32'h0);
        chk("oor_err", {31'b0, err}, 32'd1);
        chk("oor_cnt1", {24'b0, err_cnt}, 32'd1);
        cycle(1'b0, 1'b1, 32'h8000_0000, 32'h5555_AAAA);
        chk("oor_cnt2", {24'b0, err_cnt}, 32'd2);
        cycle(1'b1, 1'b0, 32'd0, 32'h0);
        idle();
        chk("oor_unchanged", rdata, 32'd100);
        cycle(1'b1, 1'b1, 32'h0001_0000, 32'h0);
        chk("oor_both", {24'b0, err_cnt}, 32'd4);

        // Saturation
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 32'h0000_0400 + i, 32'h0);
        idle();
        chk("sat_cnt", {24'b0, err_cnt}, 32'hFF);
        chk("sat_err", {31'b0, err}, 32'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 99) < 8)
                a = $urandom | (32'h1 << (10 + $urandom_range(0, 21)));
            else
                a = $urandom_range(0, 15);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom);
            rst = 1'b0;
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
